// File: rtl/axis_arb_pkg.sv
// Shared types and width helpers for the round-robin AXI-Stream arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Index width for n sources; a single source still needs one bit.
    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester strictly after last_winner,
// searching upward with wrap-around (rotate, priority-encode, unrotate).
module rr_priority_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = id_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    last_winner,
    output logic [ID_W-1:0]    pick,
    output logic               any_req
);

    logic [2*NUM_SRC-1:0] req_dbl;
    logic [ID_W:0]        start_idx;
    logic [NUM_SRC-1:0]   rotated;
    int                   offset_v;
    int                   sum_v;

    assign req_dbl = {req, req};
    assign any_req = |req;

    always_comb begin
        if (int'(last_winner) >= NUM_SRC - 1) begin
            start_idx = '0;
        end else begin
            start_idx = {1'b0, last_winner} + (ID_W+1)'(1);
        end
    end

    // Bit k of the rotated vector is source (start_idx + k) mod NUM_SRC.
    assign rotated = req_dbl[start_idx +: NUM_SRC];

    always_comb begin
        offset_v = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset_v = k;
            end
        end
        sum_v = int'(start_idx) + offset_v;
        if (sum_v >= NUM_SRC) begin
            sum_v = sum_v - NUM_SRC;
        end
        pick = ID_W'(sum_v);
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter sharing one AXI-Stream lane between
// NUM_SRC sources, with a registered, source-tagged output stage.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4,
    parameter int MAX_BEATS  = 256
) (
    input  logic                            axi_clk,
    input  logic                            axi_reset,
    input  logic [NUM_SRC-1:0]              s_axis_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_axis_data,
    input  logic [NUM_SRC-1:0]              s_axis_last,
    output logic [NUM_SRC-1:0]              s_axis_ready,
    output logic                            m_axis_valid,
    output logic [DATA_WIDTH-1:0]           m_axis_data,
    output logic                            m_axis_last,
    output logic [id_width(NUM_SRC)-1:0]    m_axis_id,
    input  logic                            m_axis_ready,
    output logic                            busy
);

    localparam int ID_W  = id_width(NUM_SRC);
    localparam int CNT_W = clog2(MAX_BEATS + 1);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       grant_idx_q, grant_idx_d;
    logic [ID_W-1:0]       last_winner_q, last_winner_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic [ID_W-1:0]       m_id_q, m_id_d;

    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
    logic [ID_W-1:0]       pick;
    logic                  any_req;
    logic                  out_free;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  src_hs;
    logic                  load_last;

    rr_priority_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_pick (
        .req         (s_axis_valid),
        .last_winner (last_winner_q),
        .pick        (pick),
        .any_req     (any_req)
    );

    assign out_free = !m_valid_q || m_axis_ready;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_data[gi]     = s_axis_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign s_axis_ready[gi] = (state_q == GRANT) && (grant_idx_q == ID_W'(gi)) && out_free;
        end
    endgenerate

    assign sel_valid = s_axis_valid[grant_idx_q];
    assign sel_last  = s_axis_last[grant_idx_q];
    assign src_hs    = (state_q == GRANT) && out_free && sel_valid;
    // The MAX_BEATS-th beat of a grant is forced to close it.
    assign load_last = sel_last || (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        last_winner_d = last_winner_q;
        beat_cnt_d    = beat_cnt_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_last_d      = m_last_q;
        m_id_d        = m_id_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_idx_d   = pick;
                    last_winner_d = pick;
                    beat_cnt_d    = '0;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (src_hs) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (load_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (src_hs) begin
            m_valid_d = 1'b1;
            m_data_d  = src_data[grant_idx_q];
            m_last_d  = load_last;
            m_id_d    = grant_idx_q;
        end else if (m_valid_q && m_axis_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_q       <= IDLE;
            grant_idx_q   <= '0;
            last_winner_q <= ID_W'(NUM_SRC - 1);
            beat_cnt_q    <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_last_q      <= 1'b0;
            m_id_q        <= '0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            last_winner_q <= last_winner_d;
            beat_cnt_q    <= beat_cnt_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_last_q      <= m_last_d;
            m_id_q        <= m_id_d;
        end
    end

    assign m_axis_valid = m_valid_q;
    assign m_axis_data  = m_data_q;
    assign m_axis_last  = m_last_q;
    assign m_axis_id    = m_id_q;
    assign busy         = (state_q == GRANT);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter (4 sources, MAX_BEATS=4).
module tb_axis_rr_arbiter;

    localparam int DW = 32;
    localparam int NS = 4;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    s_valid, s_last, s_ready;
    logic [127:0]  s_data;
    logic          m_valid, m_last, m_ready, busy;
    logic [31:0]   m_data;
    logic [1:0]    m_id;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] sq_data [4][$];
    bit          sq_last [4][$];
    bit          src_en  [4];

    logic [1:0]  log_id   [$];
    logic [31:0] log_data [$];
    bit          log_last [$];
    int          log_cyc  [$];

    always #5 clk = ~clk;

    axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .MAX_BEATS(MB)) dut (
        .axi_clk      (clk),
        .axi_reset    (rst),
        .s_axis_valid (s_valid),
        .s_axis_data  (s_data),
        .s_axis_last  (s_last),
        .s_axis_ready (s_ready),
        .m_axis_valid (m_valid),
        .m_axis_data  (m_data),
        .m_axis_last  (m_last),
        .m_axis_id    (m_id),
        .m_axis_ready (m_ready),
        .busy         (busy)
    );

    typedef struct packed {
        bit          first;
        logic [1:0]  src;
        bit          v;
        logic [31:0] d;
        bit          l;
        bit          mr;
        logic [3:0]  e_rdy;
        bit          e_mv;
        logic [31:0] e_d;
        bit          e_l;
        logic [1:0]  e_id;
        bit          e_busy;
    } vec_t;

    vec_t vec [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) begin
            sq_data[i].delete(); sq_last[i].delete(); src_en[i] = 1'b1;
        end
        log_id.delete(); log_data.delete(); log_last.delete(); log_cyc.delete();
        m_ready = 1'b1;
    endtask

    task automatic push_pkt(input int src, input logic [31:0] base, input int n);
        for (int b = 0; b < n; b++) begin
            sq_data[src].push_back(base + 32'(b));
            sq_last[src].push_back(b == n - 1);
        end
    endtask

    // One cycle of the queue-driven sources; accepted beats are popped, output beats logged.
    task automatic qcycle();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (src_en[i] && sq_data[i].size() > 0) begin
                s_valid[i] = 1'b1; s_data[i*32 +: 32] = sq_data[i][0]; s_last[i] = sq_last[i][0];
            end else begin
                s_valid[i] = 1'b0; s_data[i*32 +: 32] = '0; s_last[i] = 1'b0;
            end
        end
        #1;
        check("ready_onehot", 64'($countones(s_ready) <= 1), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (s_valid[i] && s_ready[i]) begin
                void'(sq_data[i].pop_front());
                void'(sq_last[i].pop_front());
            end
        end
        if (m_valid && m_ready) begin
            log_id.push_back(m_id); log_data.push_back(m_data);
            log_last.push_back(m_last); log_cyc.push_back(cyc);
            $display("beat cyc=%0d id=%0d data=%h last=%0d", cyc, m_id, m_data, m_last);
        end
        cyc++;
    endtask

    task automatic run_until(input string name, input int n, input int bound);
        int k;
        k = 0;
        while (log_data.size() < n && k < bound) begin
            qcycle();
            k++;
        end
        check(name, 64'(log_data.size()), 64'(n));
    endtask

    task automatic check_beat(input string name, input int idx, input logic [1:0] id,
                              input logic [31:0] d, input bit l);
        if (idx < log_data.size())
            check(name, {29'd0, log_id[idx], log_data[idx], log_last[idx]}, {29'd0, id, d, l});
        else
            check(name, 64'(log_data.size()), 64'(idx + 1));
    endtask

    initial begin
        rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b1;
        clear_all();

        // src 1, 3-beat packet, m_ready high
        vec[0]  = '{1'b1, 2'd1, 1'b1, 32'hA1, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,  1'b0, 2'd0, 1'b0};
        vec[1]  = '{1'b0, 2'd1, 1'b1, 32'hA1, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h0,  1'b0, 2'd0, 1'b1};
        vec[2]  = '{1'b0, 2'd1, 1'b1, 32'hA2, 1'b0, 1'b1, 4'b0010, 1'b1, 32'hA1, 1'b0, 2'd1, 1'b1};
        vec[3]  = '{1'b0, 2'd1, 1'b1, 32'hA3, 1'b1, 1'b1, 4'b0010, 1'b1, 32'hA2, 1'b0, 2'd1, 1'b1};
        vec[4]  = '{1'b0, 2'd1, 1'b0, 32'h0,  1'b0, 1'b1, 4'b0000, 1'b1, 32'hA3, 1'b1, 2'd1, 1'b0};
        vec[5]  = '{1'b0, 2'd1, 1'b0, 32'h0,  1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,  1'b0, 2'd0, 1'b0};
        // src 0, 4-beat packet, m_ready 1,1,1,0,0,1,...
        vec[6]  = '{1'b1, 2'd0, 1'b1, 32'hB1, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,  1'b0, 2'd0, 1'b0};
        vec[7]  = '{1'b0, 2'd0, 1'b1, 32'hB1, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h0,  1'b0, 2'd0, 1'b1};
        vec[8]  = '{1'b0, 2'd0, 1'b1, 32'hB2, 1'b0, 1'b1, 4'b0001, 1'b1, 32'hB1, 1'b0, 2'd0, 1'b1};
        vec[9]  = '{1'b0, 2'd0, 1'b1, 32'hB3, 1'b0, 1'b0, 4'b0000, 1'b1, 32'hB2, 1'b0, 2'd0, 1'b1};
        vec[10] = '{1'b0, 2'd0, 1'b1, 32'hB3, 1'b0, 1'b0, 4'b0000, 1'b1, 32'hB2, 1'b0, 2'd0, 1'b1};
        vec[11] = '{1'b0, 2'd0, 1'b1, 32'hB3, 1'b0, 1'b1, 4'b0001, 1'b1, 32'hB2, 1'b0, 2'd0, 1'b1};
        vec[12] = '{1'b0, 2'd0, 1'b1, 32'hB4, 1'b1, 1'b1, 4'b0001, 1'b1, 32'hB3, 1'b0, 2'd0, 1'b1};
        vec[13] = '{1'b0, 2'd0, 1'b0, 32'h0,  1'b0, 1'b1, 4'b0000, 1'b1, 32'hB4, 1'b1, 2'd0, 1'b0};
        vec[14] = '{1'b0, 2'd0, 1'b0, 32'h0,  1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,  1'b0, 2'd0, 1'b0};

        do_reset();
        #1;
        check("reset_state", {21'd0, s_ready, m_valid, m_data, m_last, m_id, busy},
              {21'd0, 4'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0});

        for (int r = 0; r < 15; r++) begin
            if (vec[r].first) do_reset();
            @(negedge clk);
            s_valid = '0; s_last = '0; s_data = '0;
            s_valid[vec[r].src] = vec[r].v;
            s_data[vec[r].src*32 +: 32] = vec[r].d;
            s_last[vec[r].src] = vec[r].l;
            m_ready = vec[r].mr;
            #1;
            $display("vec %0d rdy=%b mv=%0d data=%h last=%0d id=%0d busy=%0d",
                     r, s_ready, m_valid, m_data, m_last, m_id, busy);
            check($sformatf("vec%0d_ctrl", r), {58'd0, s_ready, m_valid, busy},
                  {58'd0, vec[r].e_rdy, vec[r].e_mv, vec[r].e_busy});
            if (vec[r].e_mv)
                check($sformatf("vec%0d_beat", r), {29'd0, m_data, m_last, m_id},
                      {29'd0, vec[r].e_d, vec[r].e_l, vec[r].e_id});
        end

        // Sources 0,2,3 with back-to-back 2-beat packets: order 0,2,3,0,2,3.
        do_reset(); clear_all();
        for (int p = 0; p < 2; p++) begin
            push_pkt(0, 32'h000 + 32'(p*16), 2);
            push_pkt(2, 32'h200 + 32'(p*16), 2);
            push_pkt(3, 32'h300 + 32'(p*16), 2);
        end
        run_until("rr_count", 12, 200);
        for (int g = 0; g < 6; g++) begin
            logic [1:0] sid;
            sid = (g % 3 == 0) ? 2'd0 : (g % 3 == 1) ? 2'd2 : 2'd3;
            for (int b = 0; b < 2; b++)
                check_beat($sformatf("rr_g%0d_b%0d", g, b), 2*g + b, sid,
                           (32'(sid) << 8) + 32'((g/3)*16 + b), b == 1);
            if (g < 5 && log_cyc.size() > 2*g + 2) begin
                check($sformatf("rr_inner_gap%0d", g), 64'(log_cyc[2*g+1] - log_cyc[2*g]), 64'd1);
                check($sformatf("rr_idle_gap%0d", g), 64'(log_cyc[2*g+2] - log_cyc[2*g+1]), 64'd2);
            end
        end

        // Truncation at MAX_BEATS=4, remainder re-granted after source 2.
        do_reset(); clear_all();
        push_pkt(0, 32'h30, 6);
        push_pkt(2, 32'h50, 2);
        run_until("trunc_count", 8, 100);
        check_beat("trunc_0", 0, 2'd0, 32'h30, 1'b0);
        check_beat("trunc_1", 1, 2'd0, 32'h31, 1'b0);
        check_beat("trunc_2", 2, 2'd0, 32'h32, 1'b0);
        check_beat("trunc_3", 3, 2'd0, 32'h33, 1'b1);
        check_beat("trunc_4", 4, 2'd2, 32'h50, 1'b0);
        check_beat("trunc_5", 5, 2'd2, 32'h51, 1'b1);
        check_beat("trunc_6", 6, 2'd0, 32'h34, 1'b0);
        check_beat("trunc_7", 7, 2'd0, 32'h35, 1'b1);

        // Reset on beat 2 of a 5-beat packet from source 2.
        do_reset(); clear_all();
        push_pkt(2, 32'h60, 5);
        begin
            int k;
            k = 0;
            while (sq_data[2].size() > 4 && k < 20) begin qcycle(); k++; end
            check("rst_mid_reach", 64'(sq_data[2].size()), 64'd4);
        end
        @(negedge clk);
        rst = 1'b1;
        s_data[2*32 +: 32] = sq_data[2][0]; s_last[2] = sq_last[2][0];
        @(negedge clk);
        rst = 1'b0; clear_all(); s_valid = '0; s_last = '0; s_data = '0;
        #1;
        check("rst_mid_outputs", {21'd0, s_ready, m_valid, m_data, m_last, m_id, busy},
              {21'd0, 4'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0});
        push_pkt(0, 32'h70, 2);
        push_pkt(2, 32'h80, 1);
        run_until("rst_count", 3, 50);
        check_beat("rst_first0", 0, 2'd0, 32'h70, 1'b0);
        check_beat("rst_first1", 1, 2'd0, 32'h71, 1'b1);
        check_beat("rst_then2", 2, 2'd2, 32'h80, 1'b1);

        // Granted source 1 stalls 10 cycles mid-packet while source 3 waits.
        do_reset(); clear_all();
        push_pkt(1, 32'h90, 4);
        push_pkt(3, 32'hC0, 1);
        begin
            int k;
            k = 0;
            while (sq_data[1].size() > 2 && k < 20) begin qcycle(); k++; end
            check("hold_reach", 64'(sq_data[1].size()), 64'd2);
        end
        src_en[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            qcycle();
            check($sformatf("hold_busy%0d", c), {62'd0, busy, s_ready[3]}, {62'd0, 1'b1, 1'b0});
        end
        src_en[1] = 1'b1;
        run_until("hold_count", 5, 50);
        check_beat("hold_0", 0, 2'd1, 32'h90, 1'b0);
        check_beat("hold_1", 1, 2'd1, 32'h91, 1'b0);
        check_beat("hold_2", 2, 2'd1, 32'h92, 1'b0);
        check_beat("hold_3", 3, 2'd1, 32'h93, 1'b1);
        check_beat("hold_4", 4, 2'd3, 32'hC0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
